// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and load/store,
// one access at a time, with a fetch-starvation guard on data streaks.
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        grant,
    output logic              stall
);
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, RESP} state_t;
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_DATA_STREAK);

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d, d_ready_q, d_ready_d;
    logic [1:0]        grant_q, grant_d;
    logic              data_wins;

    // With a fetch waiting, data wins only until the streak limit is reached.
    assign data_wins = d_req && !(if_req && streak_q == MAX_S);

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        grant_d     = grant_q;
        case (state_q)
            IDLE: begin
                if (data_wins) begin
                    state_d     = GNT_D;
                    grant_d     = 2'b10;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    streak_d    = !if_req ? '0 : (streak_q == MAX_S) ? streak_q : streak_q + SW'(1);
                end else if (if_req) begin
                    state_d     = GNT_IF;
                    grant_d     = 2'b01;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                end
            end
            GNT_IF, GNT_D: begin
                if (mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_ready_d = (state_q == GNT_IF);
                    d_ready_d  = (state_q == GNT_D);
                    if_rdata_d = (state_q == GNT_IF) ? mem_rdata : if_rdata_q;
                    d_rdata_d  = (state_q == GNT_D && !mem_we_q) ? mem_rdata : d_rdata_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            grant_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            grant_q     <= grant_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign grant     = grant_q;
    assign stall     = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the CPU fetch path and the load/store path.
- Serialises requests and handles variable-latency memory acknowledges.
- Produces a stall that the CPU uses as the inverse of PC_en, so a fetch and a data access in the same instruction both complete before the PC advances.
- Sits between the CPU datapath and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DATA_STREAK, 4, number of consecutive data grants allowed while a fetch waits; the next grant then goes to fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low
if_req  in  1  fetch request, held high until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, registered
if_ready  out  1  one-cycle pulse, fetch complete
d_req  in  1  data request, held high until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, registered
d_ready  out  1  one-cycle pulse, data access complete
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
mem_ack  in  1  memory completion, one cycle
grant  out  2  current owner: 00 none, 01 fetch, 10 data
stall  out  1  combinational: (if_req & ~if_ready) | (d_req & ~d_ready)

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE and streak counter clears to 0.
  - mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ready, d_ready and grant all become 0.
  - Reset has priority over every other event.
- FSM states: IDLE, GNT_IF, GNT_D, RESP.
- IDLE:
  - Requests are sampled at the edge. None pending: stay in IDLE.
  - Only d_req: go to GNT_D.
  - Only if_req: go to GNT_IF.
  - Both pending: go to GNT_D, unless streak == MAX_DATA_STREAK, in which case go to GNT_IF.
- On entering a grant state:
  - mem_addr, mem_we and mem_wdata are captured from the winning requester. For a fetch, mem_we=0 and mem_wdata=0.
  - mem_req=1 and grant is set.
  - Captured values are held stable for the whole grant; later input changes are ignored.
- GNT_x: wait for mem_ack sampled high.
  - On that edge go to RESP, drop mem_req and mem_we, and pulse x_ready=1 for the RESP cycle only.
  - On a load or fetch, capture mem_rdata into x_rdata.
  - On a store, d_rdata holds its previous value.
- RESP: unconditionally go to IDLE. No new grant is issued in RESP; grant stays at the owner during RESP.
- Requester rule: req must be low in the cycle after ready unless a new access is wanted. A registered requester clearing req on the ready edge satisfies this.
- Latency and throughput:
  - Zero-wait memory (ack in the first grant cycle): req raised before edge 0, mem_req high in cycle 1, ready in cycle 2.
  - Each access occupies 3 cycles plus memory wait states.
- Streak counter, updated on each grant decision:
  - Data grant while if_req=1: increment, saturating at MAX_DATA_STREAK.
  - Data grant while if_req=0: clear.
  - Fetch grant: clear.
- mem_ack outside the GNT states is ignored.
- x_ready never coincides with mem_req=1.
- Reset mid-grant: the transaction is abandoned, mem_req=0 after the edge, no ready is issued, and the memory model must tolerate the abort.
- Simultaneous if_req rise and d_ready in RESP: no effect until IDLE samples.

Test Plan:
- Reset: hold rst=0 for 2 cycles with if_req=d_req=1 -> all outputs 0, grant=00, no mem_req. Release -> GNT_D next edge.
- Fetch only, zero-wait: if_addr=0x10, memory returns 0x00500093 with ack in the first grant cycle -> mem_req=1, mem_we=0 in cycle 1; if_ready=1 with if_rdata=0x00500093 in cycle 2; grant=01 in cycles 1-2.
- Simultaneous store and fetch: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, if_addr=0x14, both raised together -> data served first (mem_we=1, mem_wdata=0xDEADBEEF, grant=10), d_ready pulse, then fetch served (grant=01). stall stays 1 until if_ready.
- Wait states: load d_addr=0x200, mem_ack 3 cycles after mem_req with mem_rdata=0x12345678 -> mem_req and mem_addr stable for 3 cycles, stall=1 throughout, d_ready one cycle after ack with d_rdata=0x12345678.
- Starvation guard: if_req held high, d_req re-raised immediately after each d_ready, MAX_DATA_STREAK=4 -> exactly 4 data grants, then a fetch grant, then streak restarts from 0.
- Reset mid-grant: rst=0 while in GNT_IF and ack not yet seen -> mem_req=0 next cycle, no if_ready, if_rdata=0. A late mem_ack after reset has no effect.
